// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous valid/ready FIFO with power-of-two depth and clock enable
//
// Optional build macro: FIFO_COUNT_EN adds the `count` output (current occupancy).
//
// Parameters:
//   W        data width in bits (>= 1)
//   N        capacity in entries (power of two, >= 1)
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   clk_en   clock enable; when low all state holds
//   i_valid  producer offers word on i
//   i_ready  FIFO can accept a word (not full)
//   i        write data
//   o_valid  head word available on o (not empty)
//   o_ready  consumer takes head word
//   o        head data, zero when empty
//   count    occupancy (FIFO_COUNT_EN builds only)

module sync_fifo #(
    parameter int W = 32,
    parameter int N = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [W-1:0]           i,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [W-1:0]           o
`ifdef FIFO_COUNT_EN
    ,
    output logic [$clog2(N+1)-1:0] count
`endif
);

    localparam int CW = $clog2(N + 1);
    // A depth of one needs no pointer bits; keep a single bit that is held at zero.
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]  mem [N];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [AW-1:0] wr_ptr_nxt;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [W-1:0]  head;

    assign full    = (cnt == CW'(N));
    assign empty   = (cnt == '0);
    assign i_ready = !full;
    assign o_valid = !empty;

    // Handshakes qualify on registered status only, so a pop on a full FIFO
    // does not open space for a push in the same cycle.
    assign push = clk_en & i_valid & i_ready;
    assign pop  = clk_en & o_valid & o_ready;

    generate
        if (N == 1) begin : g_single
            assign rd_ptr_nxt = '0;
            assign wr_ptr_nxt = '0;
            assign head       = mem[0];
        end else begin : g_multi
            // Power-of-two depth: pointer overflow is the modulo-N wrap.
            assign rd_ptr_nxt = rd_ptr + AW'(1);
            assign wr_ptr_nxt = wr_ptr + AW'(1);
            assign head       = mem[rd_ptr];
        end
    endgenerate

    assign o = empty ? '0 : head;

    // Storage is deliberately not reset; cnt gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FIFO_COUNT_EN
    assign count = cnt;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - randomized and directed self-checking bench for sync_fifo

module tb_sync_fifo;

    logic clk;

    // Instance A: N=4, W=8
    logic       rst_a;
    logic       clk_en_a;
    logic       i_valid_a;
    logic       i_ready_a;
    logic [7:0] i_a;
    logic       o_valid_a;
    logic       o_ready_a;
    logic [7:0] o_a;
`ifdef FIFO_COUNT_EN
    logic [2:0] count_a;
    logic [0:0] count_b;
`endif

    // Instance B: N=1, W=1
    logic       rst_b;
    logic       clk_en_b;
    logic       i_valid_b;
    logic       i_ready_b;
    logic [0:0] i_b;
    logic       o_valid_b;
    logic       o_ready_b;
    logic [0:0] o_b;

    int vectors;
    int miscompares;

    logic [7:0] q[$];

    sync_fifo #(.W(8), .N(4)) u_dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .clk_en  (clk_en_a),
        .i_valid (i_valid_a),
        .i_ready (i_ready_a),
        .i       (i_a),
        .o_valid (o_valid_a),
        .o_ready (o_ready_a),
        .o       (o_a)
`ifdef FIFO_COUNT_EN
        ,
        .count   (count_a)
`endif
    );

    sync_fifo #(.W(1), .N(1)) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .clk_en  (clk_en_b),
        .i_valid (i_valid_b),
        .i_ready (i_ready_b),
        .i       (i_b),
        .o_valid (o_valid_b),
        .o_ready (o_ready_b),
        .o       (o_b)
`ifdef FIFO_COUNT_EN
        ,
        .count   (count_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare instance A against the queue model, then apply one cycle of stimulus.
    task automatic step(input logic en, input logic iv, input logic [7:0] d, input logic rdy);
        logic       do_push;
        logic       do_pop;
        logic [7:0] drop;
        @(negedge clk);
        check("a_i_ready", 32'(i_ready_a), 32'(q.size() < 4));
        check("a_o_valid", 32'(o_valid_a), 32'(q.size() > 0));
        check("a_o", 32'(o_a), (q.size() > 0) ? 32'(q[0]) : 32'd0);
`ifdef FIFO_COUNT_EN
        check("a_count", 32'(count_a), 32'(q.size()));
`endif
        clk_en_a  = en;
        i_valid_a = iv;
        i_a       = d;
        o_ready_a = rdy;
        do_push   = en && iv && (q.size() < 4);
        do_pop    = en && rdy && (q.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            drop = q.pop_front();
        end
        if (do_push) begin
            q.push_back(d);
        end
    endtask

    initial begin
        logic [7:0] held;
        vectors     = 0;
        miscompares = 0;
        rst_a = 1'b0; clk_en_a = 1'b1; i_valid_a = 1'b0; i_a = '0; o_ready_a = 1'b0;
        rst_b = 1'b0; clk_en_b = 1'b1; i_valid_b = 1'b0; i_b = '0; o_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Fill to full, then a dropped fifth push, then drain.
        step(1, 1, 8'h11, 0);
        step(1, 1, 8'h22, 0);
        step(1, 1, 8'h33, 0);
        step(1, 1, 8'h44, 0);
        step(1, 1, 8'h55, 0);
        @(negedge clk);
        check("full_i_ready", 32'(i_ready_a), 32'd0);
        check("full_head", 32'(o_a), 32'h11);
        // Full with simultaneous pop and push: pop wins, push refused.
        step(1, 1, 8'h66, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        // Simultaneous push/pop at two entries.
        step(1, 1, 8'hA1, 0);
        step(1, 1, 8'hA2, 0);
        step(1, 1, 8'hA3, 1);
        step(1, 1, 8'hA4, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        // Wrap-around streaming at one word per cycle.
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 8'(k), 1);
        end
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        // Clock enable low holds all state.
        step(1, 1, 8'h5A, 0);
        step(1, 1, 8'h5B, 0);
        @(negedge clk);
        held = o_a;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 8'hEE, 1);
        end
        @(negedge clk);
        check("clk_en_hold_o", 32'(o_a), 32'(held));

        // Asynchronous reset asserted mid-cycle discards queued words.
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        check("rst_i_ready", 32'(i_ready_a), 32'd1);
        check("rst_o_valid", 32'(o_valid_a), 32'd0);
        check("rst_o", 32'(o_a), 32'd0);
        q.delete();
        clk_en_a = 1'b1; i_valid_a = 1'b0; o_ready_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;

        // Randomized traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                 8'($urandom), ($urandom_range(0, 2) != 0));
        end
        step(1, 0, 8'h00, 0);

        // Single-entry instance.
        @(negedge clk);
        check("b_rst_i_ready", 32'(i_ready_b), 32'd1);
        check("b_rst_o_valid", 32'(o_valid_b), 32'd0);
        i_valid_b = 1'b1; i_b = 1'b1;
        @(negedge clk);
        i_valid_b = 1'b0;
        check("b_full_i_ready", 32'(i_ready_b), 32'd0);
        check("b_full_o_valid", 32'(o_valid_b), 32'd1);
        check("b_full_o", 32'(o_b), 32'd1);
        o_ready_b = 1'b1;
        @(negedge clk);
        o_ready_b = 1'b0;
        check("b_pop_i_ready", 32'(i_ready_b), 32'd1);
        check("b_pop_o_valid", 32'(o_valid_b), 32'd0);
        check("b_pop_o", 32'(o_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
